icache_direct: RTL and testbench

Direct-mapped, one-word-per-block instruction cache between the fetch stage and the memory controller. It answers fetch requests from the datapath with `ihit`/`imemload`, which are the stall inputs to the pipeline hazard logic. On a miss it issues a single-word read to memory, fills the frame and lets the fetch hit on the following cycle. It also keeps saturating hit and miss counters for performance reporting.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/sat_counter32.sv | 19 +
 rtl/icache_direct.sv | 118 +++++++++++
 tb/tb_icache_direct.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and sizing for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam int unsigned ICACHE_SETS      = 16;
  localparam int unsigned ICACHE_IDX_W     = $clog2(ICACHE_SETS);
  localparam int unsigned ICACHE_TAG_W     = WORD_W - ICACHE_IDX_W - 2;
  // Widest tag any SETS setting can need; narrower tags are zero-extended into it.
  localparam int unsigned ICACHE_TAG_MAX_W = WORD_W - 2;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    word_t                       data;
  } icache_frame_t;

  typedef enum logic {
    COMPARE = 1'b0,
    FILL    = 1'b1
  } icache_state_t;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter32 #(
  parameter logic [31:0] CLR_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= CLR_VAL;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache with single-word fills
// and saturating hit/miss counters.
module icache_direct
  import icache_pkg::*;
#(
  parameter int unsigned SETS     = ICACHE_SETS,
  parameter word_t       CNT_INIT = '0
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = WORD_W - IDX_W - 2;
  localparam int unsigned LINE_W = WORD_W - 2;

  icache_state_t state_q, state_d;
  icache_frame_t frames_q [SETS];
  icache_frame_t req_frame_c;
  logic [LINE_W-1:0] miss_addr_q;

  logic [TAG_W-1:0] req_tag_c, fill_tag_c;
  logic [IDX_W-1:0] req_idx_c, fill_idx_c;
  logic             tag_match_c;
  logic             hit_c, miss_c, fill_done_c;
  logic             unused_offset_c;

  assign req_tag_c       = imemaddr[WORD_W-1:IDX_W+2];
  assign req_idx_c       = imemaddr[IDX_W+1:2];
  assign unused_offset_c = ^imemaddr[1:0];
  assign fill_tag_c      = miss_addr_q[LINE_W-1:IDX_W];
  assign fill_idx_c      = miss_addr_q[IDX_W-1:0];
  assign req_frame_c     = frames_q[req_idx_c];
  assign tag_match_c     = (req_frame_c.tag == ICACHE_TAG_MAX_W'(req_tag_c));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= COMPARE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COMPARE: if (miss_c)      state_d = FILL;
      FILL:    if (fill_done_c) state_d = COMPARE;
      default:                  state_d = COMPARE;
    endcase
  end

  // Lookup result and memory-side request; iREN/iaddr depend on registers only.
  always_comb begin
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = {miss_addr_q, 2'b00};
    hit_c       = 1'b0;
    miss_c      = 1'b0;
    fill_done_c = 1'b0;
    unique case (state_q)
      COMPARE: begin
        hit_c  = imemREN & req_frame_c.valid & tag_match_c;
        miss_c = imemREN & ~hit_c;
        ihit   = hit_c;
        if (hit_c) imemload = req_frame_c.data;
      end
      FILL: begin
        iREN        = 1'b1;
        fill_done_c = ~iwait;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      miss_addr_q <= '0;
    end else if (miss_c) begin
      miss_addr_q <= imemaddr[WORD_W-1:2];
    end
  end

  // Reset clears only valid bits; a fill replaces the whole frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) frames_q[i].valid <= 1'b0;
    end else if (fill_done_c) begin
      frames_q[fill_idx_c] <= '{valid: 1'b1, tag: ICACHE_TAG_MAX_W'(fill_tag_c), data: iload};
    end
  end

  sat_counter32 #(.CLR_VAL(CNT_INIT)) u_hit_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (hit_c),
    .count (hit_count)
  );

  sat_counter32 #(.CLR_VAL(CNT_INIT)) u_miss_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (miss_c),
    .count (miss_count)
  );

endmodule

// File: tb/tb_icache_direct.sv
// Randomized and directed bench for icache_direct against a set-array reference model.
module tb_icache_direct;
  import icache_pkg::*;

  localparam word_t SAT_INIT = 32'hFFFF_FFF0;

  logic  CLK = 1'b0;
  logic  RST, imemREN, iwait;
  word_t imemaddr, iload;

  logic  ihit, iREN, s_ihit, s_iREN;
  word_t imemload, iaddr, hit_count, miss_count;
  word_t s_imemload, s_iaddr, s_hit_count, s_miss_count;

  int checks = 0;
  int errors = 0;

  // reference: per-set valid / line address / data, plus pending-fill info
  bit               m_valid [16];
  logic [29:0]      m_line  [16];
  word_t            m_data  [16];
  bit               m_filling;
  logic [29:0]      m_fill_line;
  longint unsigned  m_hits, m_misses;

  always #5 CLK = ~CLK;

  icache_direct dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_direct #(.CNT_INIT(SAT_INIT)) dut_sat (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(s_ihit), .imemload(s_imemload), .iREN(s_iREN), .iaddr(s_iaddr),
    .iwait(iwait), .iload(iload), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  function automatic word_t sat(longint unsigned base, longint unsigned n);
    longint unsigned s;
    s = base + n;
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
  endfunction

  task automatic check(string tag, word_t obs, word_t exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, compare this cycle's outputs, then advance the model.
  task automatic step(bit rst, bit ren, word_t addr, bit wt, word_t ld);
    int unsigned idx;
    bit          exp_hit;
    @(negedge CLK);
    RST = rst; imemREN = ren; imemaddr = addr; iwait = wt; iload = ld;
    #1;
    idx     = 32'(addr[5:2]);
    exp_hit = !m_filling && ren && m_valid[idx] && (m_line[idx] == addr[31:2]);
    check("ihit",       32'(ihit), 32'(exp_hit));
    check("imemload",   imemload, exp_hit ? m_data[idx] : 32'h0);
    check("iREN",       32'(iREN), 32'(m_filling));
    check("iaddr",      iaddr, {m_fill_line, 2'b00});
    check("hit_count",  hit_count, sat(0, m_hits));
    check("miss_count", miss_count, sat(0, m_misses));
    check("sat_hit",    s_hit_count, sat(64'(SAT_INIT), m_hits));
    check("sat_miss",   s_miss_count, sat(64'(SAT_INIT), m_misses));
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_filling = 1'b0; m_fill_line = '0; m_hits = 0; m_misses = 0;
    end else if (m_filling) begin
      if (!wt) begin
        m_valid[m_fill_line[3:0]] = 1'b1;
        m_line[m_fill_line[3:0]]  = m_fill_line;
        m_data[m_fill_line[3:0]]  = ld;
        m_filling = 1'b0;
      end
    end else if (ren) begin
      if (exp_hit) m_hits++;
      else begin
        m_misses++;
        m_filling   = 1'b1;
        m_fill_line = addr[31:2];
      end
    end
  endtask

  initial begin
    word_t a;
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b0; iload = '0;
    m_filling = 1'b0; m_fill_line = '0; m_hits = 0; m_misses = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_line[i] = '0; m_data[i] = '0;
    end

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 32'h40, 0, 0);

    // first miss with zero-wait memory, then hit two cycles later
    repeat (3) step(0, 1, 32'h40, 0, 32'h2108_0001);
    #1;
    check("tp1_hits",   hit_count, 32'd1);
    check("tp1_misses", miss_count, 32'd1);
    repeat (5) step(0, 1, 32'h40, 0, 32'h0);
    #1;
    check("tp2_hits", hit_count, 32'd6);

    // conflict in set 0 with a slow memory, then 0x40 evicted
    step(0, 1, 32'h80, 0, 0);
    repeat (3) step(0, 1, 32'h80, 1, 32'hDEAD_0000);
    step(0, 1, 32'h80, 0, 32'hCAFE_0080);
    step(0, 1, 32'h80, 0, 0);
    repeat (3) step(0, 1, 32'h40, 0, 32'h2108_0001);

    // fetch address moves during a fill
    step(0, 1, 32'h100, 0, 0);
    step(0, 1, 32'h204, 1, 0);
    step(0, 1, 32'h204, 0, 32'h0000_0100);
    repeat (3) step(0, 1, 32'h204, 0, 32'h0000_0204);
    step(0, 1, 32'h100, 0, 0);

    // reset in the second fill cycle abandons the fill
    repeat (3) step(0, 1, 32'h40, 0, 32'h2108_0001);
    step(0, 1, 32'h3C0, 0, 0);
    step(0, 1, 32'h3C0, 1, 0);
    step(1, 1, 32'h3C0, 0, 32'hBAD0_03C0);
    #1;
    check("rst_iren",  32'(iREN), 32'h0);
    check("rst_hits",  hit_count, 32'h0);
    step(0, 1, 32'h40, 0, 32'h1111_0040);
    step(0, 1, 32'h40, 0, 32'h1111_0040);

    // randomized traffic over a small address pool
    for (int n = 0; n < 3000; n++) begin
      a = (word_t'($urandom_range(0, 1)) << 31) | (word_t'($urandom_range(0, 3)) << 6) |
          (word_t'($urandom_range(0, 15)) << 2) | word_t'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8), a,
           ($urandom_range(0, 9) < 4), $urandom);
    end

    // drive the preset counters through all-ones
    step(1, 0, 0, 0, 0);
    repeat (25) step(0, 1, 32'h0000_0ABC, 0, 32'h5A5A_0ABC);
    #1;
    check("sat_hold_hits", s_hit_count, 32'hFFFF_FFFF);
    check("plain_hits",    hit_count, 32'd23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
